sd_route_activity: RTL and testbench
====================================

Name: sd_route_activity

Overview:
- Parametrised successor to the top-level single virtual/physical SD switch.
- Routes the core's SPI bus between NUM_VSD virtual SD slots (HPS-backed images) and the physical SD card.
- Latches each slot's image-mounted state and defers a routing change while that slot's chip select is active.
- Provides a programmable-timeout bus-activity detector for the disk LED and idle gating.

Parameters:
- NUM_VSD, 2: number of slots/chip selects; slot 0 falls back to the physical card, other slots fall back to "no card".
- TIMEOUT_CYCLES, 1000000: clk_sys cycles without MOSI/MISO toggle before the bus counts as idle.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): activity counter width; localparam, not overridable.

Ports:
- clk_sys  in  1  system clock, 28 MHz.
- reset  in  1  asynchronous, active-high reset.
- img_mounted  in  NUM_VSD  one-cycle mount pulse per slot.
- img_size_nz  in  NUM_VSD  per slot: mounted image size is nonzero; sampled on the mount pulse.
- core_cs_n  in  NUM_VSD  core chip selects, active low.
- core_sclk  in  1  core SPI clock.
- core_mosi  in  1  core SPI data out.
- core_miso  out  1  routed SPI data to the core.
- vsd_ss  out  NUM_VSD  slave select to each virtual sd_card, active low.
- vsd_miso  in  NUM_VSD  data from each virtual sd_card.
- SD_CS  out  1  physical card chip select.
- SD_SCK  out  1  physical card clock.
- SD_MOSI  out  1  physical card data out.
- SD_MISO  in  1  physical card data in.
- vsd_sel  out  NUM_VSD  current per-slot routing: 1 = virtual.
- pending  out  NUM_VSD  a routing change is waiting for chip-select release.
- activity  out  1  bus active (drives LED_DISK).

Behaviour:
- Reset (asynchronous, active-high): vsd_sel=0, pending=0, activity=0, counter=TIMEOUT_CYCLES, edge registers=1. Physical card routing is active immediately after reset.
- Per-slot FSM, states:
  - S_OFF (sel=0, no pend).
  - S_ON (sel=1, no pend).
  - S_PEND (pend=1, holds pend_val).
- Mount pulse on slot i:
  - If core_cs_n[i]=1: vsd_sel[i] <= img_size_nz[i] on the next edge; state becomes S_OFF or S_ON.
  - If core_cs_n[i]=0: go to S_PEND with pend_val=img_size_nz[i]; vsd_sel[i] is unchanged.
- S_PEND:
  - First cycle with core_cs_n[i]=1: vsd_sel[i] <= pend_val, pending[i] <= 0.
  - A further mount pulse while pending overwrites pend_val. Last mount wins.
  - A mount pulse in the same cycle the CS releases applies the new value directly; pending clears.
- Routing is combinational from registered vsd_sel:
  - vsd_ss[i] = core_cs_n[i] | ~vsd_sel[i].
  - SD_CS = core_cs_n[0] | vsd_sel[0].
  - SD_SCK = core_sclk & ~vsd_sel[0].
  - SD_MOSI = core_mosi & ~vsd_sel[0].
- core_miso:
  - Source is the lowest-index asserted chip select i.
  - If vsd_sel[i]: vsd_miso[i].
  - Else if i==0: SD_MISO.
  - Else: 1 (empty slot floats high).
  - No chip select asserted: vsd_sel[0] ? vsd_miso[0] : SD_MISO.
- Activity detector:
  - Registers core_mosi and core_miso each cycle; a toggle on either clears the counter to 0.
  - Otherwise the counter increments and saturates at TIMEOUT_CYCLES. It never wraps.
  - activity = registered (counter < TIMEOUT_CYCLES), one cycle of latency after the counter.
  - A toggle at saturation restarts the count.
- Reset mid-transfer: routing snaps to physical and pending requests are discarded. The core is responsible for re-initialising the card.

Decomposition:
- Package sd_route_pkg holds:
  - slot_state_t enum {S_OFF, S_ON, S_PEND}.
  - DEFAULT_TIMEOUT = 1000000.
- One sub-module, sd_slot_ctl: the per-slot FSM (mount, cs_n, size_nz -> sel, pending), instantiated NUM_VSD times by generate.
- Top level holds the MISO priority mux and the activity counter.

Test Plan:
- Reset then core_cs_n=2'b10 with SD_MISO toggling -> core_miso follows SD_MISO; SD_CS=0; vsd_ss=2'b11; vsd_sel=0.
- Slot0 mount with size_nz=1 while cs_n[0]=1 -> vsd_sel[0]=1 next cycle; SD_CS=1, SD_SCK=0; core_miso=vsd_miso[0] when cs_n[0]=0.
- Slot0 mount while cs_n[0]=0 -> pending[0]=1, vsd_sel unchanged for 50 cycles; cs_n[0] rises -> vsd_sel[0]=1 and pending[0]=0 on the next edge.
- Two mounts during one CS-low window (1 then 0) -> after release vsd_sel[0]=0.
- Slot1 asserted with no image -> core_miso=1; physical card untouched.
- TIMEOUT_CYCLES=16, one MOSI toggle -> activity=1 for 16–17 cycles then 0. Async reset asserted mid-count -> activity=0 immediately and counter saturated.

Source files
------------

// File: rtl/sd_route_pkg.sv
// sd_route_pkg: shared types and defaults for the SD routing and activity block.
package sd_route_pkg;
    typedef enum logic [1:0] {S_OFF, S_ON, S_PEND} slot_state_t;
    localparam int DEFAULT_TIMEOUT = 1000000;
endpackage

// File: rtl/sd_slot_ctl.sv
// sd_slot_ctl: per-slot mount latch; defers a routing change until the slot's chip select releases.
module sd_slot_ctl
    import sd_route_pkg::*;
(
    input  logic clk_sys,
    input  logic reset,
    input  logic mount,
    input  logic cs_n,
    input  logic size_nz,
    output logic sel,
    output logic pending
);
    slot_state_t state_q, state_d;
    logic pend_val_q, pend_val_d, sel_d;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= S_OFF;
            pend_val_q <= 1'b0;
            sel        <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_val_q <= pend_val_d;
            sel        <= sel_d;
        end
    end

    // A mount with CS released always applies directly, even while a deferred value waits.
    always_comb begin
        state_d    = state_q;
        pend_val_d = pend_val_q;
        sel_d      = sel;
        if (mount && cs_n) begin
            sel_d   = size_nz;
            state_d = size_nz ? S_ON : S_OFF;
        end else if (mount) begin
            pend_val_d = size_nz;
            state_d    = S_PEND;
        end else if (state_q == S_PEND && cs_n) begin
            sel_d   = pend_val_q;
            state_d = pend_val_q ? S_ON : S_OFF;
        end
    end

    assign pending = state_q == S_PEND;
endmodule

// File: rtl/sd_route_activity.sv
// sd_route_activity: routes the core SPI bus between virtual SD slots and the physical card,
// and flags bus activity until TIMEOUT_CYCLES pass without a MOSI/MISO toggle.
module sd_route_activity
    import sd_route_pkg::*;
#(
    parameter int NUM_VSD        = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [NUM_VSD-1:0] img_mounted,
    input  logic [NUM_VSD-1:0] img_size_nz,
    input  logic [NUM_VSD-1:0] core_cs_n,
    input  logic               core_sclk,
    input  logic               core_mosi,
    output logic               core_miso,
    output logic [NUM_VSD-1:0] vsd_ss,
    input  logic [NUM_VSD-1:0] vsd_miso,
    output logic               SD_CS,
    output logic               SD_SCK,
    output logic               SD_MOSI,
    input  logic               SD_MISO,
    output logic [NUM_VSD-1:0] vsd_sel,
    output logic [NUM_VSD-1:0] pending,
    output logic               activity
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic mosi_q, miso_q, toggle;

    for (genvar i = 0; i < NUM_VSD; i++) begin : g_slot
        sd_slot_ctl u_slot (
            .clk_sys (clk_sys),
            .reset   (reset),
            .mount   (img_mounted[i]),
            .cs_n    (core_cs_n[i]),
            .size_nz (img_size_nz[i]),
            .sel     (vsd_sel[i]),
            .pending (pending[i])
        );
    end

    assign vsd_ss  = core_cs_n | ~vsd_sel;
    assign SD_CS   = core_cs_n[0] | vsd_sel[0];
    assign SD_SCK  = core_sclk & ~vsd_sel[0];
    assign SD_MOSI = core_mosi & ~vsd_sel[0];

    // Descending scan so the lowest asserted chip select wins; empty slots read high.
    always_comb begin
        core_miso = vsd_sel[0] ? vsd_miso[0] : SD_MISO;
        for (int i = NUM_VSD - 1; i >= 0; i--)
            if (!core_cs_n[i])
                core_miso = vsd_sel[i] ? vsd_miso[i] : (i == 0 ? SD_MISO : 1'b1);
    end

    assign toggle = (core_mosi ^ mosi_q) | (core_miso ^ miso_q);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mosi_q   <= 1'b1;
            miso_q   <= 1'b1;
            cnt      <= CNT_MAX;
            activity <= 1'b0;
        end else begin
            mosi_q   <= core_mosi;
            miso_q   <= core_miso;
            cnt      <= toggle ? '0 : (cnt == CNT_MAX ? cnt : cnt + 1'b1);
            activity <= cnt < CNT_MAX;
        end
    end
endmodule

// File: tb/tb_sd_route_activity.sv
// tb_sd_route_activity: scoreboard bench for SD routing, deferred mounts and the activity timeout.
module tb_sd_route_activity;
    localparam int O_MISO = 0, O_SS = 1, O_SDCS = 2, O_SCK = 3, O_MOSI = 4, O_SEL = 5, O_PEND = 6, O_ACT = 7;

    logic       clk_sys = 1'b0, reset = 1'b1;
    logic [1:0] img_mounted = 2'b00, img_size_nz = 2'b00, core_cs_n = 2'b11, vsd_miso = 2'b11;
    logic       core_sclk = 1'b0, core_mosi = 1'b1, SD_MISO = 1'b1;
    logic       core_miso, SD_CS, SD_SCK, SD_MOSI, activity;
    logic [1:0] vsd_ss, vsd_sel, pending;

    typedef struct {
        string       tag;
        int          id;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    int n_vec = 0, n_err = 0;

    always #5 clk_sys = ~clk_sys;

    sd_route_activity #(.NUM_VSD(2), .TIMEOUT_CYCLES(16)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .img_mounted (img_mounted),
        .img_size_nz (img_size_nz),
        .core_cs_n   (core_cs_n),
        .core_sclk   (core_sclk),
        .core_mosi   (core_mosi),
        .core_miso   (core_miso),
        .vsd_ss      (vsd_ss),
        .vsd_miso    (vsd_miso),
        .SD_CS       (SD_CS),
        .SD_SCK      (SD_SCK),
        .SD_MOSI     (SD_MOSI),
        .SD_MISO     (SD_MISO),
        .vsd_sel     (vsd_sel),
        .pending     (pending),
        .activity    (activity)
    );

    function automatic logic [31:0] observe(input int id);
        case (id)
            O_MISO:  return 32'(core_miso);
            O_SS:    return 32'(vsd_ss);
            O_SDCS:  return 32'(SD_CS);
            O_SCK:   return 32'(SD_SCK);
            O_MOSI:  return 32'(SD_MOSI);
            O_SEL:   return 32'(vsd_sel);
            O_PEND:  return 32'(pending);
            default: return 32'(activity);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int id, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.id  = id;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        @(negedge clk_sys);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.id), e.val);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic mount(input logic [1:0] slots, input logic [1:0] nz);
        img_mounted = slots;
        img_size_nz = nz;
        tick(1);
        img_mounted = 2'b00;
    endtask

    initial begin
        // reset state
        expect_out("rst_sel", O_SEL, 0);
        expect_out("rst_pend", O_PEND, 0);
        expect_out("rst_act", O_ACT, 0);
        expect_out("rst_sdcs", O_SDCS, 1);
        sample();
        tick(1);
        reset = 1'b0;

        // physical card routing on slot 0
        core_cs_n = 2'b10;
        core_sclk = 1'b1;
        for (int k = 0; k < 4; k++) begin
            SD_MISO = k[0];
            expect_out("phys_miso", O_MISO, 32'(k[0]));
            expect_out("phys_sdcs", O_SDCS, 0);
            expect_out("phys_ss", O_SS, 2'b11);
            expect_out("phys_sel", O_SEL, 0);
            expect_out("phys_sck", O_SCK, 1);
            expect_out("phys_mosi", O_MOSI, 1);
            sample();
            tick(1);
        end

        // direct mount on slot 0 while CS released
        core_cs_n = 2'b11;
        mount(2'b01, 2'b01);
        expect_out("mnt_sel", O_SEL, 2'b01);
        expect_out("mnt_pend", O_PEND, 0);
        expect_out("mnt_sdcs", O_SDCS, 1);
        expect_out("mnt_sck", O_SCK, 0);
        expect_out("mnt_mosi", O_MOSI, 0);
        sample();
        core_cs_n = 2'b10;
        vsd_miso  = 2'b10;
        SD_MISO   = 1'b1;
        expect_out("virt_miso0", O_MISO, 0);
        expect_out("virt_ss", O_SS, 2'b10);
        sample();
        vsd_miso = 2'b11;
        SD_MISO  = 1'b0;
        expect_out("virt_miso1", O_MISO, 1);
        sample();

        // unmount, then a mount deferred by an active CS
        core_cs_n = 2'b11;
        mount(2'b01, 2'b00);
        expect_out("unmnt_sel", O_SEL, 0);
        sample();
        core_cs_n = 2'b10;
        mount(2'b01, 2'b01);
        for (int k = 0; k < 50; k++) begin
            expect_out("hold_pend", O_PEND, 2'b01);
            expect_out("hold_sel", O_SEL, 0);
            sample();
            tick(1);
        end
        core_cs_n = 2'b11;
        expect_out("rel_pre_pend", O_PEND, 2'b01);
        sample();
        tick(1);
        expect_out("rel_sel", O_SEL, 2'b01);
        expect_out("rel_pend", O_PEND, 0);
        sample();

        // last mount wins during one CS-low window
        core_cs_n = 2'b10;
        mount(2'b01, 2'b01);
        mount(2'b01, 2'b00);
        expect_out("lw_pend", O_PEND, 2'b01);
        expect_out("lw_hold_sel", O_SEL, 2'b01);
        sample();
        core_cs_n = 2'b11;
        tick(1);
        expect_out("lw_sel", O_SEL, 0);
        expect_out("lw_pend_clr", O_PEND, 0);
        sample();

        // mount in the same cycle as CS release applies the new value
        core_cs_n = 2'b10;
        mount(2'b01, 2'b01);
        expect_out("sc_pend", O_PEND, 2'b01);
        sample();
        core_cs_n = 2'b11;
        mount(2'b01, 2'b00);
        expect_out("sc_sel", O_SEL, 0);
        expect_out("sc_pend_clr", O_PEND, 0);
        sample();

        // slot 1 with no image floats high; physical card untouched
        SD_MISO   = 1'b0;
        core_cs_n = 2'b01;
        expect_out("empty_miso", O_MISO, 1);
        expect_out("empty_sdcs", O_SDCS, 1);
        expect_out("empty_ss", O_SS, 2'b11);
        sample();
        core_cs_n = 2'b11;
        mount(2'b10, 2'b10);
        core_cs_n = 2'b01;
        vsd_miso  = 2'b01;
        expect_out("s1_miso", O_MISO, 0);
        expect_out("s1_ss", O_SS, 2'b01);
        expect_out("s1_sel", O_SEL, 2'b10);
        sample();
        core_cs_n = 2'b00;
        expect_out("prio_miso", O_MISO, 0);
        sample();
        SD_MISO = 1'b1;
        expect_out("prio_miso1", O_MISO, 1);
        sample();

        // activity timeout: quiet bus first, then one MOSI toggle
        core_cs_n = 2'b11;
        vsd_miso  = 2'b11;
        SD_MISO   = 1'b1;
        tick(20);
        expect_out("idle_act", O_ACT, 0);
        sample();
        core_mosi = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            expect_out($sformatf("act_%0d", k), O_ACT, 32'(k >= 2 && k <= 17));
            sample();
        end

        // async reset mid-count discards a pending mount and saturates the counter
        core_cs_n = 2'b10;
        mount(2'b01, 2'b01);
        core_mosi = 1'b1;
        tick(5);
        expect_out("mid_act", O_ACT, 1);
        expect_out("mid_pend", O_PEND, 2'b01);
        sample();
        tick(1);
        #2 reset = 1'b1;
        expect_out("arst_act", O_ACT, 0);
        expect_out("arst_sel", O_SEL, 0);
        expect_out("arst_pend", O_PEND, 0);
        sample();
        reset = 1'b0;
        tick(1);
        core_cs_n = 2'b11;
        for (int k = 0; k < 20; k++) begin
            expect_out("post_act", O_ACT, 0);
            expect_out("post_sel", O_SEL, 0);
            sample();
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
